// File: rtl/cave_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cave_input_ctrl
// Purpose  : PS/2 key decode merged with hps_io joysticks, coin pulse stretch,
//            registered player/service controls in clk_sys.
// Revision : 1.0 - initial release
// ============================================================================
module cave_input_ctrl #(
  parameter int COIN_PULSE_CYCLES = 4800000,
  parameter int CNT_W             = $clog2(COIN_PULSE_CYCLES + 1)
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joystick_0,
  input  logic [31:0] joystick_1,
  input  logic        osd_active,
  output logic [3:0]  p1_dir,
  output logic [2:0]  p1_buttons,
  output logic        p1_start,
  output logic        p1_coin,
  output logic        p1_pause,
  output logic [3:0]  p2_dir,
  output logic [2:0]  p2_buttons,
  output logic        p2_start,
  output logic        p2_coin,
  output logic        p2_pause,
  output logic        service_1,
  output logic        service_2
);

  localparam int c_NUM_KEYS  = 21;
  localparam int c_K_UP      = 0;
  localparam int c_K_DOWN    = 1;
  localparam int c_K_LEFT    = 2;
  localparam int c_K_RIGHT   = 3;
  localparam int c_K_P1B1    = 4;
  localparam int c_K_P1B2    = 5;
  localparam int c_K_P1B3    = 6;
  localparam int c_K_P1START = 7;
  localparam int c_K_P2START = 8;
  localparam int c_K_P1COIN  = 9;
  localparam int c_K_P2COIN  = 10;
  localparam int c_K_SVC1    = 11;
  localparam int c_K_SVC2    = 12;
  localparam int c_K_P1PAUSE = 13;
  localparam int c_K_P2UP    = 14;
  localparam int c_K_P2DOWN  = 15;
  localparam int c_K_P2LEFT  = 16;
  localparam int c_K_P2RIGHT = 17;
  localparam int c_K_P2B1    = 18;
  localparam int c_K_P2B2    = 19;
  localparam int c_K_P2B3    = 20;

  localparam logic [CNT_W-1:0] c_COIN_LOAD = CNT_W'(COIN_PULSE_CYCLES - 1);

  logic                  r_old_toggle;
  logic                  r_primed;
  logic [c_NUM_KEYS-1:0] r_keys;
  logic [c_NUM_KEYS-1:0] w_key_sel;
  logic                  w_event;

  logic [3:0] w_p1_dir, w_p2_dir;
  logic [2:0] w_p1_btn, w_p2_btn;
  logic [1:0] w_coin_raw;
  logic [1:0] w_coin_out;

  logic [3:0] r_p1_dir, r_p2_dir;
  logic [2:0] r_p1_btn, r_p2_btn;
  logic       r_p1_start, r_p1_pause, r_p2_start, r_p2_pause;
  logic       r_service_1, r_service_2;

  // Extended flag and the upper joystick bits carry nothing for this core.
  logic w_unused;
  assign w_unused = &{1'b0, ps2_key[8], joystick_0[31:11], joystick_1[31:11]};

  always_comb begin
    w_key_sel = '0;
    case (ps2_key[7:0])
      8'h75: w_key_sel[c_K_UP]      = 1'b1;
      8'h72: w_key_sel[c_K_DOWN]    = 1'b1;
      8'h6B: w_key_sel[c_K_LEFT]    = 1'b1;
      8'h74: w_key_sel[c_K_RIGHT]   = 1'b1;
      8'h14: w_key_sel[c_K_P1B1]    = 1'b1;
      8'h11: w_key_sel[c_K_P1B2]    = 1'b1;
      8'h29: w_key_sel[c_K_P1B3]    = 1'b1;
      8'h16: w_key_sel[c_K_P1START] = 1'b1;
      8'h1E: w_key_sel[c_K_P2START] = 1'b1;
      8'h2E: w_key_sel[c_K_P1COIN]  = 1'b1;
      8'h36: w_key_sel[c_K_P2COIN]  = 1'b1;
      8'h46: w_key_sel[c_K_SVC1]    = 1'b1;
      8'h45: w_key_sel[c_K_SVC2]    = 1'b1;
      8'h4D: w_key_sel[c_K_P1PAUSE] = 1'b1;
      8'h2D: w_key_sel[c_K_P2UP]    = 1'b1;
      8'h2B: w_key_sel[c_K_P2DOWN]  = 1'b1;
      8'h23: w_key_sel[c_K_P2LEFT]  = 1'b1;
      8'h34: w_key_sel[c_K_P2RIGHT] = 1'b1;
      8'h1C: w_key_sel[c_K_P2B1]    = 1'b1;
      8'h1B: w_key_sel[c_K_P2B2]    = 1'b1;
      8'h15: w_key_sel[c_K_P2B3]    = 1'b1;
      default: ;
    endcase
  end

  // The first toggle seen after reset is stale and must not be replayed.
  assign w_event = r_primed && (ps2_key[10] != r_old_toggle) && !osd_active;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_old_toggle <= 1'b0;
      r_primed     <= 1'b0;
      r_keys       <= '0;
    end else begin
      r_old_toggle <= ps2_key[10];
      r_primed     <= 1'b1;
      if (osd_active)
        r_keys <= '0;
      else if (w_event)
        r_keys <= (r_keys & ~w_key_sel) | (w_key_sel & {c_NUM_KEYS{ps2_key[9]}});
    end
  end

  assign w_p1_dir = {r_keys[c_K_UP]    | joystick_0[3], r_keys[c_K_DOWN]  | joystick_0[2],
                     r_keys[c_K_LEFT]  | joystick_0[1], r_keys[c_K_RIGHT] | joystick_0[0]};
  assign w_p1_btn = {r_keys[c_K_P1B3]  | joystick_0[6], r_keys[c_K_P1B2]  | joystick_0[5],
                     r_keys[c_K_P1B1]  | joystick_0[4]};
  assign w_p2_dir = {r_keys[c_K_P2UP]   | joystick_1[3], r_keys[c_K_P2DOWN]  | joystick_1[2],
                     r_keys[c_K_P2LEFT] | joystick_1[1], r_keys[c_K_P2RIGHT] | joystick_1[0]};
  assign w_p2_btn = {r_keys[c_K_P2B3]  | joystick_1[6], r_keys[c_K_P2B2]  | joystick_1[5],
                     r_keys[c_K_P2B1]  | joystick_1[4]};
  assign w_coin_raw = {r_keys[c_K_P2COIN] | joystick_1[8], r_keys[c_K_P1COIN] | joystick_0[8]};

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_p1_dir    <= '0;
      r_p1_btn    <= '0;
      r_p1_start  <= 1'b0;
      r_p1_pause  <= 1'b0;
      r_p2_dir    <= '0;
      r_p2_btn    <= '0;
      r_p2_start  <= 1'b0;
      r_p2_pause  <= 1'b0;
      r_service_1 <= 1'b0;
      r_service_2 <= 1'b0;
    end else begin
      r_p1_dir    <= w_p1_dir;
      r_p1_btn    <= w_p1_btn;
      r_p1_start  <= r_keys[c_K_P1START] | joystick_0[7];
      r_p1_pause  <= r_keys[c_K_P1PAUSE] | joystick_0[9];
      r_p2_dir    <= w_p2_dir;
      r_p2_btn    <= w_p2_btn;
      r_p2_start  <= r_keys[c_K_P2START] | joystick_1[7];
      r_p2_pause  <= joystick_1[9];
      r_service_1 <= r_keys[c_K_SVC1] | joystick_0[10];
      r_service_2 <= r_keys[c_K_SVC2] | joystick_1[10];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_coin
    logic             r_raw_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             w_rise;

    assign w_rise = w_coin_raw[gi] & ~r_raw_d;

    // r_cnt holds the high cycles still owed beyond the one being output now.
    always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
        r_raw_d <= 1'b0;
        r_cnt   <= '0;
        r_out   <= 1'b0;
      end else begin
        r_raw_d <= w_coin_raw[gi];
        r_out   <= w_coin_raw[gi] | (r_cnt != '0);
        if (w_rise)
          r_cnt <= c_COIN_LOAD;
        else if (r_cnt != '0)
          r_cnt <= r_cnt - CNT_W'(1);
      end
    end

    assign w_coin_out[gi] = r_out;
  end

  assign p1_dir     = r_p1_dir;
  assign p1_buttons = r_p1_btn;
  assign p1_start   = r_p1_start;
  assign p1_coin    = w_coin_out[0];
  assign p1_pause   = r_p1_pause;
  assign p2_dir     = r_p2_dir;
  assign p2_buttons = r_p2_btn;
  assign p2_start   = r_p2_start;
  assign p2_coin    = w_coin_out[1];
  assign p2_pause   = r_p2_pause;
  assign service_1  = r_service_1;
  assign service_2  = r_service_2;

endmodule
`default_nettype wire

// File: tb/tb_cave_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cave_input_ctrl
// Purpose  : Self-checking bench for cave_input_ctrl (COIN_PULSE_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cave_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        RESET;
  logic [10:0] ps2_key;
  logic [31:0] joystick_0, joystick_1;
  logic        osd_active;
  logic [3:0]  p1_dir, p2_dir;
  logic [2:0]  p1_buttons, p2_buttons;
  logic        p1_start, p1_coin, p1_pause, p2_start, p2_coin, p2_pause;
  logic        service_1, service_2;

  cave_input_ctrl #(.COIN_PULSE_CYCLES(16)) dut (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1), .osd_active(osd_active),
    .p1_dir(p1_dir), .p1_buttons(p1_buttons), .p1_start(p1_start),
    .p1_coin(p1_coin), .p1_pause(p1_pause),
    .p2_dir(p2_dir), .p2_buttons(p2_buttons), .p2_start(p2_start),
    .p2_coin(p2_coin), .p2_pause(p2_pause),
    .service_1(service_1), .service_2(service_2)
  );

  always #5 clk_sys = ~clk_sys;

  // {p1_dir, p1_btn, p1 start/coin/pause, p2_dir, p2_btn, p2 start/coin/pause, svc1/svc2}
  logic [21:0] obs;
  assign obs = {p1_dir, p1_buttons, p1_start, p1_coin, p1_pause,
                p2_dir, p2_buttons, p2_start, p2_coin, p2_pause, service_1, service_2};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { string name; logic [21:0] val; } exp_t;
  exp_t sb[$];

  typedef struct { logic [31:0] j0; logic [31:0] j1; logic [21:0] exp; } vec_t;
  typedef struct { logic [7:0] code; logic [21:0] exp; } key_t;
  vec_t vecs[14];
  key_t keys[15];

  // p2_coin run-length monitor, sampled away from the active edge
  int run_len = 0, last_run = 0, n_runs = 0;
  always @(negedge clk_sys) begin
    if (p2_coin) run_len++;
    else if (run_len > 0) begin
      last_run = run_len;
      n_runs++;
      run_len = 0;
    end
  end

  logic tog = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [21:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      e = sb.pop_front();
      check(e.name, {10'b0, obs}, {10'b0, e.val});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] code, input logic pressed);
    tog = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
  endtask

  initial begin
    vecs[0]  = '{32'h008, 32'h0, {4'b1000, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    vecs[1]  = '{32'h004, 32'h0, {4'b0100, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    vecs[2]  = '{32'h002, 32'h0, {4'b0010, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    vecs[3]  = '{32'h001, 32'h0, {4'b0001, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    vecs[4]  = '{32'h070, 32'h0, {4'b0000, 3'b111, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    vecs[5]  = '{32'h010, 32'h0, {4'b0000, 3'b001, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    vecs[6]  = '{32'h080, 32'h0, {4'b0000, 3'b000, 3'b100, 4'b0000, 3'b000, 3'b000, 2'b00}};
    vecs[7]  = '{32'h200, 32'h0, {4'b0000, 3'b000, 3'b001, 4'b0000, 3'b000, 3'b000, 2'b00}};
    vecs[8]  = '{32'h400, 32'h0, {4'b0000, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b10}};
    vecs[9]  = '{32'h0, 32'h009, {4'b0000, 3'b000, 3'b000, 4'b1001, 3'b000, 3'b000, 2'b00}};
    vecs[10] = '{32'h0, 32'h060, {4'b0000, 3'b000, 3'b000, 4'b0000, 3'b110, 3'b000, 2'b00}};
    vecs[11] = '{32'h0, 32'h680, {4'b0000, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b101, 2'b01}};
    vecs[12] = '{32'hFFFFF800, 32'hFFFFF800, 22'h0};
    vecs[13] = '{32'h6FF, 32'h6FF, {4'b1111, 3'b111, 3'b101, 4'b1111, 3'b111, 3'b101, 2'b11}};

    keys[0]  = '{8'h75, {4'b1000, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    keys[1]  = '{8'h6B, {4'b0010, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    keys[2]  = '{8'h74, {4'b0001, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    keys[3]  = '{8'h29, {4'b0000, 3'b100, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    keys[4]  = '{8'h11, {4'b0000, 3'b010, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b00}};
    keys[5]  = '{8'h16, {4'b0000, 3'b000, 3'b100, 4'b0000, 3'b000, 3'b000, 2'b00}};
    keys[6]  = '{8'h4D, {4'b0000, 3'b000, 3'b001, 4'b0000, 3'b000, 3'b000, 2'b00}};
    keys[7]  = '{8'h1E, {4'b0000, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b100, 2'b00}};
    keys[8]  = '{8'h2B, {4'b0000, 3'b000, 3'b000, 4'b0100, 3'b000, 3'b000, 2'b00}};
    keys[9]  = '{8'h34, {4'b0000, 3'b000, 3'b000, 4'b0001, 3'b000, 3'b000, 2'b00}};
    keys[10] = '{8'h1C, {4'b0000, 3'b000, 3'b000, 4'b0000, 3'b001, 3'b000, 2'b00}};
    keys[11] = '{8'h15, {4'b0000, 3'b000, 3'b000, 4'b0000, 3'b100, 3'b000, 2'b00}};
    keys[12] = '{8'h46, {4'b0000, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b10}};
    keys[13] = '{8'h45, {4'b0000, 3'b000, 3'b000, 4'b0000, 3'b000, 3'b000, 2'b01}};
    keys[14] = '{8'h99, 22'h0};

    // Reset with every joystick bit held
    RESET = 1'b1; ps2_key = '0; joystick_0 = 32'hFFFFFFFF; joystick_1 = '0; osd_active = 1'b0;
    push("reset_outputs", 22'h0);
    tick(3);
    pop_check();
    push("reset_release", {4'hF, 3'h7, 3'b111, 4'h0, 3'h0, 3'b000, 2'b10});
    @(negedge clk_sys); RESET = 1'b0;
    tick(1);
    pop_check();
    tick(20);
    check("p1_coin_held", {31'b0, p1_coin}, 32'd1);
    joystick_0 = '0;
    push("joy_release", 22'h0);
    tick(1);
    pop_check();

    // Joystick merge table, 1-cycle latency
    for (int i = 0; i < 14; i++) begin
      joystick_0 = vecs[i].j0;
      joystick_1 = vecs[i].j1;
      push($sformatf("merge_vec%0d", i), vecs[i].exp);
      tick(1);
      pop_check();
    end
    joystick_0 = '0; joystick_1 = '0;
    tick(2);

    // Key latency: nothing after one cycle, output after two
    send(8'h75, 1'b1);
    tick(1);
    check("key_lat1", {28'b0, p1_dir}, 32'h0);
    tick(1);
    check("key_lat2", {28'b0, p1_dir}, 32'h8);
    send(8'h75, 1'b0);
    tick(2);
    check("key_release", {28'b0, p1_dir}, 32'h0);

    // Key map table: press then release
    for (int i = 0; i < 15; i++) begin
      send(keys[i].code, 1'b1);
      push($sformatf("key_press_%h", keys[i].code), keys[i].exp);
      tick(2);
      pop_check();
      send(keys[i].code, 1'b0);
      push($sformatf("key_rel_%h", keys[i].code), 22'h0);
      tick(2);
      pop_check();
    end

    // OSD clears held keys and swallows events while open
    send(8'h14, 1'b1);
    tick(2);
    check("osd_pre", {29'b0, p1_buttons}, 32'h1);
    osd_active = 1'b1;
    tick(2);
    check("osd_clear", {29'b0, p1_buttons}, 32'h0);
    send(8'h14, 1'b1);
    tick(2);
    check("osd_event_blocked", {29'b0, p1_buttons}, 32'h0);
    osd_active = 1'b0;
    tick(3);
    check("osd_event_dropped", {29'b0, p1_buttons}, 32'h0);
    send(8'h14, 1'b1);
    tick(2);
    check("post_osd_press", {29'b0, p1_buttons}, 32'h1);
    send(8'h14, 1'b0);
    tick(2);

    // Coin minimum width, single-cycle raw pulse
    begin
      int n0;
      n0 = n_runs;
      joystick_1 = 32'h100; tick(1); joystick_1 = '0;
      tick(30);
      check("coin_min_runs", n_runs - n0, 32'd1);
      check("coin_min_width", last_run, 32'd16);

      n0 = n_runs;
      joystick_1 = 32'h100; tick(40); joystick_1 = '0;
      tick(30);
      check("coin_long_runs", n_runs - n0, 32'd1);
      check("coin_long_width", last_run, 32'd40);

      n0 = n_runs;
      joystick_1 = 32'h100; tick(1); joystick_1 = '0;
      tick(9);
      joystick_1 = 32'h100; tick(1); joystick_1 = '0;
      tick(40);
      check("coin_retrig_runs", n_runs - n0, 32'd1);
      check("coin_retrig_width", last_run, 32'd26);
    end

    // Reset mid-stretch clears coin asynchronously; then the prime guard
    joystick_1 = 32'h100; tick(1); joystick_1 = '0;
    tick(5);
    check("coin_mid_stretch", {31'b0, p2_coin}, 32'd1);
    #2 RESET = 1'b1;
    #1 check("coin_async_reset", {31'b0, p2_coin}, 32'd0);
    tog = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
    @(negedge clk_sys); RESET = 1'b0;
    push("prime_guard", 22'h0);
    tick(3);
    pop_check();
    send(8'h16, 1'b1);
    tick(2);
    check("prime_next_toggle", {31'b0, p1_start}, 32'd1);
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
